// File: rtl/sdram_tester_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_tester_pkg : run-state encoding and SDRAM test pattern  (Rev 1.0)
// ---------------------------------------------------------------------------
package sdram_tester_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int ERR_W = 16;

   // Computed at a fixed 64-bit width; callers keep the low DW bits.
   function automatic logic [63:0] pattern(input logic [63:0] a,
                                           input logic [63:0] seed,
                                           input logic        inv);
      return a ^ seed ^ {64{inv}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_tester_chk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_tester_chk : read-return tracking, compare, error count/first address
// Rev 1.0
// ---------------------------------------------------------------------------
module sdram_tester_chk
   import sdram_tester_pkg::*;
#(
   parameter int              AW      = 22,
   parameter int              DW      = 16,
   parameter int              NWORDS  = 2**AW,
   parameter int              MAX_OUT = 4,
   parameter logic [DW-1:0]   SEED    = DW'(16'hA5C3),
   parameter int              OW      = $clog2(MAX_OUT + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_clear,
   input  logic               i_acc,
   input  logic               i_rvalid,
   input  logic [DW-1:0]      i_rdata,
   input  logic               i_inv,
   output logic [OW-1:0]      o_out_nxt,
   output logic               o_last,
   output logic               o_clean_nxt,
   output logic [ERR_W-1:0]   o_err_cnt,
   output logic [AW-1:0]      o_first_err_addr
);

   localparam logic [AW:0] C_LAST = (AW+1)'(NWORDS - 1);

   logic [OW-1:0]    r_out;
   logic [AW:0]      r_chk;
   logic [ERR_W-1:0] r_err;
   logic [AW-1:0]    r_first;

   logic             w_ret;
   logic             w_mis;
   logic [DW-1:0]    w_exp;

   // Returns with nothing outstanding are stale (e.g. from before a reset).
   assign w_ret       = i_rvalid && (r_out != '0);
   assign w_exp       = DW'(pattern(64'(r_chk), 64'(SEED), i_inv));
   assign w_mis       = w_ret && (i_rdata != w_exp);
   assign o_last      = w_ret && (r_chk == C_LAST);
   assign o_clean_nxt = (r_err == '0) && !w_mis;

   always_comb begin
      o_out_nxt = r_out;
      if (i_acc && !w_ret)
         o_out_nxt = r_out + 1'b1;
      else if (!i_acc && w_ret)
         o_out_nxt = r_out - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n || i_clear) begin
         r_out   <= '0;
         r_chk   <= '0;
         r_err   <= '0;
         r_first <= '0;
      end else begin
         r_out <= o_out_nxt;
         if (w_ret)
            r_chk <= r_chk + 1'b1;
         if (w_mis) begin
            if (r_err != '1)
               r_err <= r_err + 1'b1;
            if (r_err == '0)
               r_first <= r_chk[AW-1:0];
         end
      end
   end

   assign o_err_cnt        = r_err;
   assign o_first_err_addr = r_first;

endmodule
`default_nettype wire

// File: rtl/sdram_avl_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_avl_tester : Avalon-MM pattern write / pipelined readback SDRAM tester
// Rev 1.0
// ---------------------------------------------------------------------------
module sdram_avl_tester
   import sdram_tester_pkg::*;
#(
   parameter int              AW      = 22,
   parameter int              DW      = 16,
   parameter int              NWORDS  = 2**AW,
   parameter int              MAX_OUT = 4,
   parameter logic [DW-1:0]   SEED    = DW'(16'hA5C3)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               invert,
   output logic [AW-1:0]      avm_address,
   output logic               avm_write,
   output logic [DW-1:0]      avm_writedata,
   output logic               avm_read,
   output logic [DW/8-1:0]    avm_byteenable,
   input  logic               avm_waitrequest,
   input  logic [DW-1:0]      avm_readdata,
   input  logic               avm_readdatavalid,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_cnt,
   output logic [AW-1:0]      first_err_addr
);

   localparam int            OW     = $clog2(MAX_OUT + 1);
   localparam logic [AW:0]   C_LAST = (AW+1)'(NWORDS - 1);
   localparam logic [AW:0]   C_NW   = (AW+1)'(NWORDS);
   localparam logic [OW-1:0] C_MAX  = OW'(MAX_OUT);

   state_t          r_state;
   logic            r_inv;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic            r_avm_write;
   logic            r_avm_read;
   logic [AW-1:0]   r_avm_address;
   logic [DW-1:0]   r_avm_writedata;
   logic [AW:0]     r_wr_addr;
   logic [AW:0]     r_rd_addr;

   logic            w_start_acc;
   logic            w_wr_acc;
   logic            w_rd_acc;
   logic [AW:0]     w_wr_nxt;
   logic [AW:0]     w_rd_nxt;
   logic [DW-1:0]   w_wdata_nxt;
   logic [DW-1:0]   w_wdata_first;
   logic [OW-1:0]   w_out_nxt;
   logic            w_last;
   logic            w_clean_nxt;

   assign w_start_acc   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_wr_acc      = r_avm_write && !avm_waitrequest;
   assign w_rd_acc      = r_avm_read && !avm_waitrequest;
   assign w_wr_nxt      = r_wr_addr + 1'b1;
   assign w_rd_nxt      = r_rd_addr + {{AW{1'b0}}, w_rd_acc};
   assign w_wdata_nxt   = DW'(pattern(64'(w_wr_nxt), 64'(SEED), r_inv));
   assign w_wdata_first = DW'(pattern(64'd0, 64'(SEED), invert));

   sdram_tester_chk #(
      .AW      (AW),
      .DW      (DW),
      .NWORDS  (NWORDS),
      .MAX_OUT (MAX_OUT),
      .SEED    (SEED),
      .OW      (OW)
   ) u_chk (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_clear          (w_start_acc),
      .i_acc            (w_rd_acc),
      .i_rvalid         (avm_readdatavalid),
      .i_rdata          (avm_readdata),
      .i_inv            (r_inv),
      .o_out_nxt        (w_out_nxt),
      .o_last           (w_last),
      .o_clean_nxt      (w_clean_nxt),
      .o_err_cnt        (err_cnt),
      .o_first_err_addr (first_err_addr)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state         <= ST_IDLE;
         r_inv           <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_pass          <= 1'b0;
         r_avm_write     <= 1'b0;
         r_avm_read      <= 1'b0;
         r_avm_address   <= '0;
         r_avm_writedata <= '0;
         r_wr_addr       <= '0;
         r_rd_addr       <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state         <= ST_WRITE;
                  r_inv           <= invert;
                  r_busy          <= 1'b1;
                  r_done          <= 1'b0;
                  r_pass          <= 1'b0;
                  r_wr_addr       <= '0;
                  r_avm_write     <= 1'b1;
                  r_avm_address   <= '0;
                  r_avm_writedata <= w_wdata_first;
               end
            end
            ST_WRITE: begin
               if (w_wr_acc) begin
                  if (r_wr_addr == C_LAST) begin
                     // Nothing is outstanding yet, so the first read can go out immediately.
                     r_state       <= ST_READ;
                     r_avm_write   <= 1'b0;
                     r_avm_read    <= 1'b1;
                     r_avm_address <= '0;
                     r_rd_addr     <= '0;
                  end else begin
                     r_wr_addr       <= w_wr_nxt;
                     r_avm_address   <= w_wr_nxt[AW-1:0];
                     r_avm_writedata <= w_wdata_nxt;
                  end
               end
            end
            ST_READ: begin
               r_rd_addr     <= w_rd_nxt;
               r_avm_address <= w_rd_nxt[AW-1:0];
               if (w_last) begin
                  r_state    <= ST_DONE;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_pass     <= w_clean_nxt;
                  r_avm_read <= 1'b0;
               end else begin
                  // A stalled read keeps its slot: the count can only fall until it is accepted.
                  r_avm_read <= (w_rd_nxt < C_NW) && (w_out_nxt < C_MAX);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign avm_address    = r_avm_address;
   assign avm_write      = r_avm_write;
   assign avm_writedata  = r_avm_writedata;
   assign avm_read       = r_avm_read;
   assign avm_byteenable = '1;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;

endmodule
`default_nettype wire
